// File: rtl/hotspot_locate_if.sv
`default_nettype none
// ============================================================================
// Module      : hotspot_locate_if
// Description : Energy-sample stream plus hotspot overlay coordinate bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface hotspot_locate_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sof;
    logic [DW-1:0]        in_data;
    logic                 ena;
    logic signed [31:0]   pix_x;
    logic signed [31:0]   pix_y;

    // master: sample source and overlay consumer; slave: the locator itself
    modport master (
        output in_valid, in_sof, in_data,
        input  in_ready, ena, pix_x, pix_y
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output in_ready, ena, pix_x, pix_y
    );
endinterface
`default_nettype wire

// File: rtl/hotspot_locate.sv
`default_nettype none
// ============================================================================
// Module      : hotspot_locate
// Description : Tracks the per-frame energy peak and emits a smoothed pixel
//               hotspot coordinate for the overlay renderer.
// Revision    : 1.0 - initial release
// ============================================================================
module hotspot_locate #(
    parameter int DW           = 16,
    parameter int GRID_W       = 48,
    parameter int GRID_H       = 34,
    parameter int X_SCALE      = 10,
    parameter int Y_SCALE      = 8,
    parameter int X_OFFSET     = 5,
    parameter int Y_OFFSET     = 4,
    parameter int THRESH       = 256,
    parameter int SMOOTH_SHIFT = 2
) (
    input  wire logic           clk_pix,
    input  wire logic           rst,
    hotspot_locate_if.slave     bus,
    output logic [DW-1:0]       peak_val,
    output logic                frame_err
);

    localparam int c_COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int c_ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(GRID_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(GRID_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
    localparam logic [DW-1:0]      c_THRESH   = DW'(THRESH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_CALC  = 2'd2;
    localparam logic [1:0] c_ST_OUT   = 2'd3;

    logic [1:0]          r_state;
    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_COL_W-1:0]  r_max_col;
    logic [c_ROW_W-1:0]  r_max_row;
    logic [DW-1:0]       r_max;
    logic [DW-1:0]       r_peak;
    logic signed [31:0]  r_tgt_x;
    logic signed [31:0]  r_tgt_y;
    logic signed [31:0]  r_pix_x;
    logic signed [31:0]  r_pix_y;
    logic                r_first_hit;
    logic                r_ena;
    logic                r_frame_err;

    logic                w_ready;
    logic                w_xfer;
    logic                w_sof_xfer;
    logic                w_data_xfer;
    logic                w_col_end;
    logic                w_last;
    logic                w_take;
    logic signed [31:0]  w_tgt_x;
    logic signed [31:0]  w_tgt_y;
    logic signed [31:0]  w_dx;
    logic signed [31:0]  w_dy;
    logic signed [31:0]  w_step_x;
    logic signed [31:0]  w_step_y;

    assign w_ready     = (r_state == c_ST_IDLE) || (r_state == c_ST_ACCUM);
    assign w_xfer      = bus.in_valid && w_ready;
    assign w_sof_xfer  = w_xfer && bus.in_sof;
    assign w_data_xfer = w_xfer && !bus.in_sof && (r_state == c_ST_ACCUM);
    assign w_col_end   = (r_col == c_COL_LAST);
    assign w_last      = w_col_end && (r_row == c_ROW_LAST);
    // strict compare keeps the earliest raster position on ties
    assign w_take      = bus.in_data > r_max;

    assign w_tgt_x  = $signed(32'(r_max_col)) * 32'(X_SCALE) + 32'(X_OFFSET);
    assign w_tgt_y  = $signed(32'(r_max_row)) * 32'(Y_SCALE) + 32'(Y_OFFSET);
    assign w_dx     = r_tgt_x - r_pix_x;
    assign w_dy     = r_tgt_y - r_pix_y;
    assign w_step_x = w_dx >>> SMOOTH_SHIFT;
    assign w_step_y = w_dy >>> SMOOTH_SHIFT;

    // Frame sequencing and raster position
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_sof_xfer) begin
                        r_col   <= c_COL_ONE;
                        r_row   <= '0;
                        r_state <= c_ST_ACCUM;
                    end
                end
                c_ST_ACCUM: begin
                    if (w_sof_xfer) begin
                        // premature start of frame: drop the partial frame and restart
                        r_frame_err <= 1'b1;
                        r_col       <= c_COL_ONE;
                        r_row       <= '0;
                    end else if (w_data_xfer) begin
                        if (w_last) begin
                            r_state <= c_ST_CALC;
                        end else if (w_col_end) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                c_ST_CALC: begin
                    r_state <= (r_max >= c_THRESH) ? c_ST_OUT : c_ST_IDLE;
                end
                c_ST_OUT: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Running maximum and its grid position
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_max     <= '0;
            r_max_col <= '0;
            r_max_row <= '0;
        end else if (w_sof_xfer) begin
            r_max     <= bus.in_data;
            r_max_col <= '0;
            r_max_row <= '0;
        end else if (w_data_xfer && w_take) begin
            r_max     <= bus.in_data;
            r_max_col <= r_col;
            r_max_row <= r_row;
        end
    end

    // Pixel-space target, smoothing and output registers
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_tgt_x     <= '0;
            r_tgt_y     <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_peak      <= '0;
            r_first_hit <= 1'b0;
            r_ena       <= 1'b0;
        end else begin
            r_ena <= 1'b0;
            if (r_state == c_ST_CALC) begin
                r_tgt_x <= w_tgt_x;
                r_tgt_y <= w_tgt_y;
            end
            if (r_state == c_ST_OUT) begin
                if (!r_first_hit) begin
                    r_pix_x     <= r_tgt_x;
                    r_pix_y     <= r_tgt_y;
                    r_first_hit <= 1'b1;
                end else begin
                    r_pix_x <= r_pix_x + w_step_x;
                    r_pix_y <= r_pix_y + w_step_y;
                end
                r_peak <= r_max;
                r_ena  <= 1'b1;
            end
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.ena      = r_ena;
    assign bus.pix_x    = r_pix_x;
    assign bus.pix_y    = r_pix_y;
    assign peak_val     = r_peak;
    assign frame_err    = r_frame_err;

endmodule
`default_nettype wire
